// File: rtl/pwm_pkg.sv
// Shared definitions for the Avalon-MM PWM output stage: register offsets,
// bus handshake states and the signed-to-duty saturation helper.
package pwm_pkg;

  localparam int DUTY_OFS   = 0;
  localparam int PERIOD_OFS = 1;
  localparam int CTRL_OFS   = 2;
  localparam int ACTIVE_OFS = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } bus_state_t;

  // Clamp a signed control word into 0 .. 2^w-1.
  function automatic logic [31:0] sat_duty(input logic signed [31:0] x, input int w);
    logic [31:0] max_val;
    max_val = (32'd1 << w) - 32'd1;
    if (x[31])
      return 32'd0;
    else if ($unsigned(x) > max_val)
      return max_val;
    else
      return $unsigned(x);
  endfunction

endpackage

// File: rtl/avmm_pwm_core.sv
// PWM frame engine: period counter, double-buffered duty load at the wrap,
// registered compare output and period-start strobe.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] pending_duty,
  input  logic             enable,
  output logic             pwm_out,
  output logic             period_start,
  output logic [CNT_W-1:0] active_duty
);

  logic [CNT_W-1:0] cnt;
  logic             enable_q;
  logic             wrap;
  logic             restart;

  // >= rather than == so a period shrunk below the running count still wraps.
  assign wrap    = (cnt >= period);
  assign restart = enable && !enable_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      enable_q     <= 1'b1;
      active_duty  <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      enable_q <= enable;
      if (!enable) begin
        cnt          <= '0;
        pwm_out      <= 1'b0;
        period_start <= 1'b0;
      end else if (restart) begin
        cnt          <= '0;
        active_duty  <= pending_duty;
        period_start <= 1'b1;
        pwm_out      <= 1'b0;
      end else begin
        cnt          <= wrap ? '0 : cnt + 1'b1;
        period_start <= wrap;
        if (wrap)
          active_duty <= pending_duty;
        pwm_out <= (cnt < active_duty);
      end
    end
  end

endmodule

// File: rtl/avmm_pwm_out.sv
// Avalon-MM slave feeding pwm_core: fixed-latency waitrequest handshake plus
// DUTY/PERIOD/CTRL registers. Define AVMM_PWM_READBACK_EN to add a read port.
module avmm_pwm_out
  import pwm_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hDEAD,
  parameter int          CNT_W      = 12,
  parameter int          ACCEPT_LAT = 5,
  parameter int          PERIOD_RST = 4095
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      pwm_address,
  input  logic             pwm_write,
  input  logic [31:0]      pwm_writedata,
`ifdef AVMM_PWM_READBACK_EN
  input  logic             pwm_read,
  output logic [31:0]      pwm_readdata,
  output logic             pwm_readdatavalid,
`endif
  output logic             pwm_waitrequest,
  output logic             pwm_out,
  output logic             period_start,
  output logic [CNT_W-1:0] active_duty
);

  localparam int LAT_W = (ACCEPT_LAT > 1) ? $clog2(ACCEPT_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((ACCEPT_LAT > 0) ? ACCEPT_LAT - 1 : 0);

  bus_state_t       state, next_state;
  logic [LAT_W-1:0] lat_cnt, next_lat;
  logic [15:0]      offset;
  logic             req, held, do_write;
  logic [CNT_W-1:0] pending_duty, period_reg;
  logic             ctrl_enable;

  assign offset = pwm_address - BASE_ADDR;

`ifdef AVMM_PWM_READBACK_EN
  logic op_is_write;
  logic do_read;

  // Writes win over a simultaneous read; the read is served on a later pass.
  assign req      = pwm_write | pwm_read;
  assign held     = op_is_write ? pwm_write : pwm_read;
  assign do_write = (state == ACK) && op_is_write;
  assign do_read  = (state == ACK) && !op_is_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      op_is_write <= 1'b0;
    else if (state == IDLE && req)
      op_is_write <= pwm_write;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_readdata      <= '0;
      pwm_readdatavalid <= 1'b0;
    end else begin
      pwm_readdatavalid <= do_read;
      if (do_read) begin
        case (offset)
          16'(DUTY_OFS):   pwm_readdata <= 32'(pending_duty);
          16'(PERIOD_OFS): pwm_readdata <= 32'(period_reg);
          16'(CTRL_OFS):   pwm_readdata <= {31'b0, ctrl_enable};
          16'(ACTIVE_OFS): pwm_readdata <= 32'(active_duty);
          default:         pwm_readdata <= '0;
        endcase
      end
    end
  end
`else
  assign req      = pwm_write;
  assign held     = pwm_write;
  assign do_write = (state == ACK);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      lat_cnt         <= '0;
      pwm_waitrequest <= 1'b1;
    end else begin
      state           <= next_state;
      lat_cnt         <= next_lat;
      pwm_waitrequest <= (next_state != ACK);
    end
  end

  always_comb begin
    next_state = state;
    next_lat   = lat_cnt;
    case (state)
      IDLE: begin
        if (req) begin
          next_lat   = '0;
          next_state = (ACCEPT_LAT == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!held)
          next_state = IDLE;
        else if (lat_cnt == LAT_LAST)
          next_state = ACK;
        else
          next_lat = lat_cnt + 1'b1;
      end
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Unknown offsets still complete the handshake; the data is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_duty <= '0;
      period_reg   <= CNT_W'(PERIOD_RST);
      ctrl_enable  <= 1'b1;
    end else if (do_write) begin
      case (offset)
        16'(DUTY_OFS):   pending_duty <= CNT_W'(sat_duty($signed(pwm_writedata), CNT_W));
        16'(PERIOD_OFS): period_reg   <= (pwm_writedata[CNT_W-1:0] == '0) ? CNT_W'(1)
                                                                       : pwm_writedata[CNT_W-1:0];
        16'(CTRL_OFS):   ctrl_enable  <= pwm_writedata[0];
        default: ;
      endcase
    end
  end

  pwm_core #(.CNT_W(CNT_W)) u_core (
    .clk          (clk),
    .reset        (reset),
    .period       (period_reg),
    .pending_duty (pending_duty),
    .enable       (ctrl_enable),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .active_duty  (active_duty)
  );

endmodule

// File: tb/tb_avmm_pwm_out.sv
// Self-checking bench for avmm_pwm_out: directed frames plus randomized
// PERIOD/DUTY/junk writes checked against a per-frame arithmetic model.
module tb_avmm_pwm_out;

  localparam logic [15:0] BASE       = 16'hDEAD;
  localparam int          CNT_W      = 12;
  localparam int          ACCEPT_LAT = 5;
  localparam int          PERIOD_RST = 4095;
  localparam int          DUTY_MAX   = (1 << CNT_W) - 1;
  localparam int          WAIT_BOUND = 8200;

  logic             clk = 1'b0;
  logic             reset;
  logic [15:0]      pwm_address;
  logic             pwm_write;
  logic [31:0]      pwm_writedata;
  logic             pwm_waitrequest;
  logic             pwm_out;
  logic             period_start;
  logic [CNT_W-1:0] active_duty;
`ifdef AVMM_PWM_READBACK_EN
  logic             pwm_read;
  logic [31:0]      pwm_readdata;
  logic             pwm_readdatavalid;
`endif

  int checks = 0;
  int errors = 0;

  // Register-level reference state.
  int ref_pending;
  int ref_period;
  int ref_enable;

  avmm_pwm_out #(
    .BASE_ADDR  (BASE),
    .CNT_W      (CNT_W),
    .ACCEPT_LAT (ACCEPT_LAT),
    .PERIOD_RST (PERIOD_RST)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pwm_address       (pwm_address),
    .pwm_write         (pwm_write),
    .pwm_writedata     (pwm_writedata),
`ifdef AVMM_PWM_READBACK_EN
    .pwm_read          (pwm_read),
    .pwm_readdata      (pwm_readdata),
    .pwm_readdatavalid (pwm_readdatavalid),
`endif
    .pwm_waitrequest   (pwm_waitrequest),
    .pwm_out           (pwm_out),
    .period_start      (period_start),
    .active_duty       (active_duty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  function automatic int sat_ref(input int x);
    if (x < 0) return 0;
    if (x > DUTY_MAX) return DUTY_MAX;
    return x;
  endfunction

  function automatic void model_reset();
    ref_pending = 0;
    ref_period  = PERIOD_RST;
    ref_enable  = 1;
  endfunction

  function automatic void model_write(input logic [15:0] addr, input logic [31:0] data);
    logic [15:0] off;
    int p;
    off = addr - BASE;
    p   = int'(data[CNT_W-1:0]);
    case (off)
      16'd0:   ref_pending = sat_ref(int'(data));
      16'd1:   ref_period  = (p == 0) ? 1 : p;
      16'd2:   ref_enable  = int'(data[0]);
      default: ;
    endcase
  endfunction

  // One full write transaction; checks accept latency and single-cycle ack.
  task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] data);
    int lat;
    @(posedge clk); #1;
    pwm_address   = addr;
    pwm_writedata = data;
    pwm_write     = 1'b1;
    for (lat = 0; lat <= 64; lat++) begin
      @(negedge clk);
      if (!pwm_waitrequest) break;
    end
    checkOutput("accept_lat", lat, ACCEPT_LAT + 1);
    @(posedge clk); #1;
    pwm_write = 1'b0;
    model_write(addr, data);
    @(negedge clk);
    checkOutput("ack_one_cycle", pwm_waitrequest, 1'b1);
  endtask

  // Measures one PWM frame: length between strobes and high count, where
  // pwm_out trails the counter by one cycle.
  task automatic measure_frame(input string tag, input bit at_start, input int exp_duty);
    int waited, len, highs, exp_highs;
    if (!at_start) begin
      for (waited = 0; waited <= WAIT_BOUND; waited++) begin
        @(negedge clk);
        if (period_start) break;
      end
      checkOutput({tag, "_start"}, period_start, 1'b1);
    end
    checkOutput({tag, "_active"}, active_duty, exp_duty);
    len   = 0;
    highs = 0;
    do begin
      @(negedge clk);
      len++;
      highs += int'(pwm_out);
    end while (!period_start && len <= WAIT_BOUND);
    exp_highs = (exp_duty < ref_period + 1) ? exp_duty : ref_period + 1;
    checkOutput({tag, "_len"}, len, ref_period + 1);
    checkOutput({tag, "_highs"}, highs, exp_highs);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset         = 1'b1;
    pwm_address   = '0;
    pwm_write     = 1'b0;
    pwm_writedata = '0;
`ifdef AVMM_PWM_READBACK_EN
    pwm_read      = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("rst_waitreq", pwm_waitrequest, 1'b1);
    checkOutput("rst_pwm", pwm_out, 1'b0);
    checkOutput("rst_ps", period_start, 1'b0);
    checkOutput("rst_active", active_duty, 0);
    reset = 1'b0;

    $display("[TB] duty 2048 at default period");
    applyStimulus(BASE, 32'd2048);
    measure_frame("d2048", 1'b0, ref_pending);

    $display("[TB] saturation: -20 then 5000");
    applyStimulus(BASE, -32'sd20);
    measure_frame("dneg", 1'b0, ref_pending);
    applyStimulus(BASE, 32'd5000);
    measure_frame("dbig", 1'b0, ref_pending);

    $display("[TB] short period and period clamp");
    applyStimulus(BASE + 16'd1, 32'd9);
    applyStimulus(BASE, 32'd3);
    measure_frame("p9", 1'b0, ref_pending);
    applyStimulus(BASE + 16'd1, 32'd0);
    measure_frame("p0", 1'b0, ref_pending);

    $display("[TB] duty commit on the wrap cycle");
    applyStimulus(BASE + 16'd1, 32'd9);
    measure_frame("sync", 1'b0, ref_pending);
    repeat (2) @(posedge clk);
    applyStimulus(BASE, 32'd7);
    checkOutput("wrap_ps", period_start, 1'b1);
    measure_frame("wrap_old", 1'b1, 3);
    measure_frame("wrap_new", 1'b1, 7);

    $display("[TB] enable off and on");
    applyStimulus(BASE + 16'd2, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("dis_pwm", pwm_out, 1'b0);
      checkOutput("dis_ps", period_start, 1'b0);
    end
    applyStimulus(BASE, 32'd4);
    checkOutput("dis_active_hold", active_duty, 7);
    applyStimulus(BASE + 16'd2, 32'd1);
    @(negedge clk);
    checkOutput("en_ps", period_start, 1'b1);
    checkOutput("en_active", active_duty, ref_pending);
    measure_frame("en", 1'b1, ref_pending);

    $display("[TB] unmapped addresses");
    applyStimulus(BASE + 16'd7, 32'h1234_5678);
    applyStimulus(BASE + 16'd3, 32'd100);
    measure_frame("junk", 1'b0, ref_pending);

    $display("[TB] randomized period/duty");
    for (int it = 0; it < 12; it++) begin
      int pval;
      int dval;
      pval = int'($urandom_range(0, 30));
      applyStimulus(BASE + 16'd1, pval);
      case ($urandom_range(0, 3))
        0:       dval = -int'($urandom_range(1, 100000));
        1:       dval = int'($urandom_range(0, 40));
        2:       dval = int'($urandom_range(4096, 1 << 30));
        default: dval = int'($urandom_range(0, 4095));
      endcase
      if ($urandom_range(0, 1) == 1)
        applyStimulus(BASE + 16'(3 + $urandom_range(0, 60000)), $urandom);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      applyStimulus(BASE, dval);
      measure_frame("rnd", 1'b0, ref_pending);
    end

    $display("[TB] reset during WAIT");
    @(posedge clk); #1;
    pwm_address   = BASE;
    pwm_writedata = 32'd100;
    pwm_write     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_waitreq", pwm_waitrequest, 1'b1);
    checkOutput("midrst_active", active_duty, 0);
    pwm_write = 1'b0;
    reset     = 1'b0;
    model_reset();
    for (int i = 0; i < ACCEPT_LAT + 3; i++) begin
      @(negedge clk);
      checkOutput("postrst_waitreq", pwm_waitrequest, 1'b1);
    end
    applyStimulus(BASE + 16'd1, 32'd5);
    measure_frame("postrst_p5", 1'b0, ref_pending);
    applyStimulus(BASE, 32'd2);
    measure_frame("postrst_d2", 1'b0, ref_pending);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avmm_pwm_out.md
Name: avmm_pwm_out

Overview:
- Avalon-MM write slave that is the downstream stage of pid_control: accepts the PID's signed control word on the pwm_* bus and drives a single-bit PWM output.
- Saturates signed writes into the duty range.
- Double-buffers duty so changes take effect only at a period boundary.
- Exposes a period-start strobe so the loop can be aligned to the PWM frame.

Parameters:
- BASE_ADDR, 16'hDEAD, word address of DUTY register; PERIOD at BASE_ADDR+1, CTRL at BASE_ADDR+2
- CNT_W, 12, width of period counter, duty and period registers
- ACCEPT_LAT, 5, cycles waitrequest stays high after write is first seen before the accept cycle (0 allowed)
- PERIOD_RST, 4095, reset value of PERIOD register (counter runs 0..PERIOD)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pwm_address  in  16  Avalon-MM word address
- pwm_write  in  1  write request, held by master until accepted
- pwm_writedata  in  32  write data; signed two's complement for DUTY
- pwm_waitrequest  out  1  registered; high = not accepted
- pwm_out  out  1  registered PWM output
- period_start  out  1  one-cycle pulse when counter wraps to 0
- active_duty  out  CNT_W  duty currently applied (status/debug)

Behaviour:
- Reset values:
  - pwm_waitrequest=1, pwm_out=0, period_start=0, active_duty=0
  - pending duty=0, PERIOD=PERIOD_RST, CTRL.enable=1
  - counter=0, FSM=IDLE
- Write FSM, all transitions on posedge clk:
  - IDLE: waitrequest=1. On pwm_write=1, go to WAIT with lat_cnt=0, or to ACK directly if ACCEPT_LAT=0.
  - WAIT: lat_cnt increments each cycle. When lat_cnt==ACCEPT_LAT-1, go to ACK (waitrequest registered low for the next cycle).
  - ACK: waitrequest=0 for exactly one cycle; the write is committed in this cycle using the address/data present. Return to IDLE with waitrequest=1.
  - If pwm_write drops in WAIT (protocol violation), return to IDLE with no commit.
- Address decode, applied at the commit cycle only:
  - BASE_ADDR: pending_duty = sat(writedata).
  - BASE_ADDR+1: PERIOD = writedata[CNT_W-1:0], clamped to a minimum of 1.
  - BASE_ADDR+2: CTRL.enable = writedata[0].
  - Other addresses: accepted (waitrequest handshake completes) and discarded.
- Saturation sat(x), with x treated as signed 32-bit:
  - x<0 -> 0
  - x>2^CNT_W-1 -> 2^CNT_W-1
  - otherwise x[CNT_W-1:0]
- Counter:
  - When enable=1: increments each cycle; at counter==PERIOD wraps to 0.
  - period_start is registered high in the cycle the counter equals 0 after a wrap.
  - When enable=0: counter held at 0, pwm_out=0, period_start=0.
- Shadow update: active_duty <= pending_duty on the wrap cycle only. A commit on the wrap cycle itself takes effect at the next wrap (the pending register is written in parallel; active loads the old pending).
- Output: pwm_out <= enable && (counter < active_duty), registered, so pwm_out lags the counter by one cycle.
  - active_duty=0 -> constant 0.
  - active_duty > PERIOD -> constant 1.
- Enable 0->1 transition:
  - Counter restarts at 0.
  - active_duty loads pending_duty immediately.
  - period_start pulses.
- Reset mid-transaction: FSM returns to IDLE and no commit occurs; the master must reissue the write.

Optional Feature:
- Macro: AVMM_PWM_READBACK_EN.
- Defined: adds ports pwm_read (in, 1), pwm_readdata (out, 32) and pwm_readdatavalid (out, 1).
  - Reads use the same FSM and latency as writes.
  - One cycle after ACK, pwm_readdatavalid=1 with zero-extended data:
    - BASE_ADDR -> pending_duty
    - BASE_ADDR+1 -> PERIOD
    - BASE_ADDR+2 -> {31'b0, enable}
    - BASE_ADDR+3 -> active_duty
  - Simultaneous read and write gives write priority; the read waits for the next FSM pass.
- Undefined: read ports are absent and the slave is write-only.

Decomposition:
- Package pwm_pkg holds:
  - register offsets: DUTY_OFS=0, PERIOD_OFS=1, CTRL_OFS=2, ACTIVE_OFS=3
  - the FSM state enum (IDLE, WAIT, ACK)
  - function sat_duty(logic signed [31:0], int w)
- One sub-module, pwm_core: counter, shadow load, compare and period_start; takes period, pending_duty and enable.
- The top level holds the Avalon FSM and registers.

Test Plan:
- Reset, then write 2048 to BASE_ADDR with ACCEPT_LAT=5 -> waitrequest low exactly one cycle, 6 cycles after write is asserted; active_duty=2048 after next period_start; pwm_out high for 2048 of 4096 cycles.
- Write -20 then 5000 -> active_duty=0 (pwm_out constant 0), then 4095 (pwm_out low 1 cycle per 4096-cycle period).
- Set PERIOD=9, write duty=3 -> period_start every 10 cycles, pwm_out high 3 cycles; write PERIOD=0 -> behaves as PERIOD=1, period 2 cycles.
- Commit duty on the wrap cycle -> new duty appears one full period later, not immediately.
- CTRL.enable=0 mid-period -> pwm_out=0 next cycle, counter held 0; enable=1 -> period_start pulse and restart from 0 with the pending duty.
- Write to BASE_ADDR+7 -> handshake completes, no register changes; reset asserted during WAIT -> no commit, waitrequest=1.
